hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Sits beside the opcode Control decoder.
- Detects load-use and jr-operand hazards, branch/jump redirects, and data-memory wait states.
- Drives PC/IF-ID write enables, IF-ID flush, ID-EX bubble and a global pipeline freeze.
- Keeps saturating stall/flush counters and a memory-wait watchdog.

---
 rtl/hazard_stall_ctrl_pkg.sv | 21 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 19 +
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: jump codes,
// memory access codes and the memory-wait FSM states.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_J    = 2'b01;
    localparam logic [1:0] J_JAL  = 2'b10;
    localparam logic [1:0] J_JR   = 2'b11;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_W    = 2'b01;
    localparam logic [1:0] MEM_B    = 2'b10;
    localparam logic [1:0] MEM_H    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: hazard
// stalls, redirect flushes, memory-wait freeze and a sticky wait watchdog.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [1:0]       id_jump,
    input  logic [1:0]       ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_dest,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              lu;
    logic              jrh;
    logic              freeze;

    assign mem_wait = mem_req & ~mem_ready;
    assign lu  = (ex_mem_read != MEM_NONE) && (ex_dest != 5'd0) &&
                 ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    assign jrh = (id_jump == J_JR) && ex_reg_write && (ex_dest != 5'd0) &&
                 (ex_dest == id_rs);
    assign freeze = (state == ST_ERR) || mem_wait;

    // One action per cycle; a branch seen while frozen waits because EX is held.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu || jrh) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_jump != J_NONE) begin
                ifid_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!mem_wait) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        state       <= ST_ERR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and randomized bench for hazard_stall_ctrl against a cycle-level
// reference model built from the hazard priority rules.
module tb_hazard_stall_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 3;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_dest;
    logic             id_uses_rt, ex_reg_write, ex_branch_taken, mem_req, mem_ready;
    logic [1:0]       id_jump, ex_mem_read;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_run;   // consecutive wait cycles seen
    bit m_err;
    int m_sc, m_fc;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urt, input int jmp,
                          input int mr, input bit rw, input int dst, input bit bt,
                          input bit req, input bit rdy);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt; id_jump = 2'(jmp);
        ex_mem_read = 2'(mr); ex_reg_write = rw; ex_dest = 5'(dst);
        ex_branch_taken = bt; mem_req = req; mem_ready = rdy;
    endtask

    task automatic model_clear();
        m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
    endtask

    // Check this cycle's outputs against the model, then advance one clock.
    task automatic step(input string tag);
        bit w, l, j, e_pc, e_fl, e_bub, e_frz;
        #1;
        w = mem_req && !mem_ready;
        l = (ex_mem_read != 0) && (ex_dest != 0) &&
            ((ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt));
        j = (id_jump == 3) && ex_reg_write && (ex_dest != 0) && (ex_dest == id_rs);
        e_frz = m_err || w;
        e_pc  = 1; e_fl = 0; e_bub = 0;
        if (e_frz)                begin e_pc = 0; end
        else if (ex_branch_taken) begin e_fl = 1; e_bub = 1; end
        else if (l || j)          begin e_pc = 0; e_bub = 1; end
        else if (id_jump != 0)    begin e_fl = 1; end
        chk({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
        chk({tag, ".ifid_write"},  32'(ifid_write),  32'(e_pc));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        chk({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'(e_frz));
        chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_err));
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_sc));
        chk({tag, ".flush_cnt"},   32'(flush_cnt),   32'(m_fc));
        @(posedge clk);
        if (!e_pc && m_sc < SAT) m_sc++;
        if (e_fl && m_fc < SAT)  m_fc++;
        if (!m_err) begin
            if (w) begin
                m_run++;
                if (m_run == MAX_WAIT) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".pc_write"},    32'(pc_write),    32'd1);
        chk({tag, ".ifid_write"},  32'(ifid_write),  32'd1);
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'd0);
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd0);
        chk({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'd0);
        chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'd0);
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'd0);
        chk({tag, ".flush_cnt"},   32'(flush_cnt),   32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_clear();
        @(negedge clk);
        do_reset("reset");

        // load-use on rs: one bubble, then run
        set_in(5, 0, 0, 0, 1, 1, 5, 0, 0, 1); step("lu_rs");
        set_in(5, 0, 0, 0, 0, 0, 5, 0, 0, 1); step("lu_after");
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // load-use on rt only when rt is read
        set_in(1, 7, 1, 0, 2, 1, 7, 0, 0, 1); step("lu_rt");
        set_in(1, 7, 0, 0, 2, 1, 7, 0, 0, 1); step("lu_rt_unused");

        // branch beats stall
        do_reset("rst_b");
        set_in(5, 0, 0, 0, 1, 1, 5, 1, 0, 1); step("br_vs_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("br_after");
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // jr hazard, then jump
        set_in(31, 0, 0, 3, 0, 1, 31, 0, 0, 1); step("jr_stall");
        set_in(31, 0, 0, 3, 0, 0, 31, 0, 0, 1); step("jr_go");
        chk("jr_flush_cnt", 32'(flush_cnt), 32'd2);

        // register 0 never hazards
        set_in(0, 0, 1, 0, 1, 1, 0, 0, 0, 1); step("r0");
        chk("r0_stall_cnt", 32'(stall_cnt), 32'd1);

        // three-cycle memory wait, branch held during freeze
        do_reset("rst_w");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step("wait1");
        step("wait2");
        step("wait3");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step("wait_done");
        chk("wait_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("wait_timeout",   32'(mem_timeout), 32'd0);

        // watchdog: wait held 10 cycles, freeze persists after it drops
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step("wdog");
        chk("wdog_timeout", 32'(mem_timeout), 32'd1);
        set_in(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        step("err_hold");
        step("err_hold2");
        do_reset("rst_err");

        // randomized traffic, occasionally resetting out of ERR
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                   1'($urandom), ($urandom_range(0, 3) != 0));
            if (m_err && $urandom_range(0, 7) == 0) do_reset("rnd_rst");
            else step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
